// File: rtl/chirp_sequencer.sv
// chirp_sequencer: latches a chirp configuration on start, steps the NCO
// frequency word from f_start by a signed f_step with a programmable dwell per
// step, repeats for a burst of chirps separated by idle gaps, and emits
// sync/done strobes. All outputs are registered.
//
// Handshake: there is no valid/ready pair. start is level-sampled only in IDLE;
// abort acts in SWEEP/GAP and blocks start in IDLE; ena low freezes every
// register while forcing the chirp_sync/done strobes low.
module chirp_sequencer #(
    parameter int FW = 16,
    parameter int SW = 8,
    parameter int DW = 8,
    parameter int BW = 4
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_ena,
    input  logic          i_start,
    input  logic          i_abort,
    input  logic [FW-1:0] i_f_start,
    input  logic [FW-1:0] i_f_step,
    input  logic [SW-1:0] i_n_steps,
    input  logic [DW-1:0] i_dwell,
    input  logic [DW-1:0] i_gap,
    input  logic [BW-1:0] i_n_chirps,
    output logic [FW-1:0] o_freq,
    output logic          o_nco_en,
    output logic          o_chirp_sync,
    output logic          o_busy,
    output logic          o_done,
    output logic [BW-1:0] o_chirp_cnt
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SWEEP = 2'd1,
        S_GAP   = 2'd2
    } state_t;

    // Current state
    state_t        r_state;
    logic [FW-1:0] r_freq;
    logic          r_nco_en;
    logic          r_chirp_sync;
    logic          r_busy;
    logic          r_done;
    logic [BW-1:0] r_chirp_cnt;
    logic [FW-1:0] r_f_start;
    logic [FW-1:0] r_f_step;
    logic [SW-1:0] r_n_steps;
    logic [DW-1:0] r_dwell;
    logic [DW-1:0] r_gap;
    logic [BW-1:0] r_n_chirps;
    logic [DW-1:0] r_dwell_cnt;
    logic [SW-1:0] r_step_cnt;
    logic [DW-1:0] r_gap_cnt;

    // Next state
    state_t        w_state;
    logic [FW-1:0] w_freq;
    logic          w_nco_en;
    logic          w_chirp_sync;
    logic          w_busy;
    logic          w_done;
    logic [BW-1:0] w_chirp_cnt;
    logic [FW-1:0] w_f_start;
    logic [FW-1:0] w_f_step;
    logic [SW-1:0] w_n_steps;
    logic [DW-1:0] w_dwell;
    logic [DW-1:0] w_gap;
    logic [BW-1:0] w_n_chirps;
    logic [DW-1:0] w_dwell_cnt;
    logic [SW-1:0] w_step_cnt;
    logic [DW-1:0] w_gap_cnt;

    // State register: synchronous active-low reset, otherwise load next values
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state      <= S_IDLE;
            r_freq       <= '0;
            r_nco_en     <= 1'b0;
            r_chirp_sync <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_chirp_cnt  <= '0;
            r_f_start    <= '0;
            r_f_step     <= '0;
            r_n_steps    <= '0;
            r_dwell      <= '0;
            r_gap        <= '0;
            r_n_chirps   <= '0;
            r_dwell_cnt  <= '0;
            r_step_cnt   <= '0;
            r_gap_cnt    <= '0;
        end else begin
            r_state      <= w_state;
            r_freq       <= w_freq;
            r_nco_en     <= w_nco_en;
            r_chirp_sync <= w_chirp_sync;
            r_busy       <= w_busy;
            r_done       <= w_done;
            r_chirp_cnt  <= w_chirp_cnt;
            r_f_start    <= w_f_start;
            r_f_step     <= w_f_step;
            r_n_steps    <= w_n_steps;
            r_dwell      <= w_dwell;
            r_gap        <= w_gap;
            r_n_chirps   <= w_n_chirps;
            r_dwell_cnt  <= w_dwell_cnt;
            r_step_cnt   <= w_step_cnt;
            r_gap_cnt    <= w_gap_cnt;
        end
    end

    // Next-state and registered-output logic; everything holds by default and
    // the two strobes default low, which also covers the ena-low freeze
    always_comb begin
        w_state      = r_state;
        w_freq       = r_freq;
        w_nco_en     = r_nco_en;
        w_chirp_sync = 1'b0;
        w_busy       = r_busy;
        w_done       = 1'b0;
        w_chirp_cnt  = r_chirp_cnt;
        w_f_start    = r_f_start;
        w_f_step     = r_f_step;
        w_n_steps    = r_n_steps;
        w_dwell      = r_dwell;
        w_gap        = r_gap;
        w_n_chirps   = r_n_chirps;
        w_dwell_cnt  = r_dwell_cnt;
        w_step_cnt   = r_step_cnt;
        w_gap_cnt    = r_gap_cnt;

        if (!i_ena) begin
            // frozen: hold everything, strobes already forced low
        end else if (i_abort) begin
            // abort in IDLE only blocks start; in SWEEP/GAP drop to reset values
            if (r_state != S_IDLE) begin
                w_state     = S_IDLE;
                w_freq      = '0;
                w_nco_en    = 1'b0;
                w_busy      = 1'b0;
                w_chirp_cnt = '0;
                w_dwell_cnt = '0;
                w_step_cnt  = '0;
                w_gap_cnt   = '0;
            end
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        w_state      = S_SWEEP;
                        w_f_start    = i_f_start;
                        w_f_step     = i_f_step;
                        w_n_steps    = i_n_steps;
                        w_dwell      = i_dwell;
                        w_gap        = i_gap;
                        w_n_chirps   = i_n_chirps;
                        w_freq       = i_f_start;
                        w_nco_en     = 1'b1;
                        w_busy       = 1'b1;
                        w_chirp_sync = 1'b1;
                        w_chirp_cnt  = '0;
                        w_dwell_cnt  = '0;
                        w_step_cnt   = '0;
                        w_gap_cnt    = '0;
                    end
                end
                S_SWEEP: begin
                    if (r_dwell_cnt != r_dwell) begin
                        w_dwell_cnt = r_dwell_cnt + DW'(1);
                    end else begin
                        w_dwell_cnt = '0;
                        if (r_step_cnt != r_n_steps) begin
                            w_step_cnt = r_step_cnt + SW'(1);
                            w_freq     = r_freq + r_f_step;
                        end else if (r_chirp_cnt == r_n_chirps) begin
                            // last step of the last chirp: burst complete
                            w_state    = S_IDLE;
                            w_freq     = '0;
                            w_nco_en   = 1'b0;
                            w_busy     = 1'b0;
                            w_done     = 1'b1;
                            w_step_cnt = '0;
                        end else begin
                            w_chirp_cnt = r_chirp_cnt + BW'(1);
                            w_step_cnt  = '0;
                            if (r_gap == '0) begin
                                w_freq       = r_f_start;
                                w_chirp_sync = 1'b1;
                            end else begin
                                w_state   = S_GAP;
                                w_freq    = '0;
                                w_nco_en  = 1'b0;
                                w_gap_cnt = '0;
                            end
                        end
                    end
                end
                S_GAP: begin
                    // r_gap is nonzero here, so gap cycles are counted 0..gap-1
                    if (r_gap_cnt == r_gap - DW'(1)) begin
                        w_state      = S_SWEEP;
                        w_freq       = r_f_start;
                        w_nco_en     = 1'b1;
                        w_chirp_sync = 1'b1;
                        w_gap_cnt    = '0;
                        w_dwell_cnt  = '0;
                        w_step_cnt   = '0;
                    end else begin
                        w_gap_cnt = r_gap_cnt + DW'(1);
                    end
                end
                default: begin
                    w_state  = S_IDLE;
                    w_freq   = '0;
                    w_nco_en = 1'b0;
                    w_busy   = 1'b0;
                end
            endcase
        end
    end

    assign o_freq       = r_freq;
    assign o_nco_en     = r_nco_en;
    assign o_chirp_sync = r_chirp_sync;
    assign o_busy       = r_busy;
    assign o_done       = r_done;
    assign o_chirp_cnt  = r_chirp_cnt;

endmodule

// File: tb/tb_chirp_sequencer.sv
// Bench for chirp_sequencer. A reference model expands each launched burst into
// the full per-cycle output trace from the burst rules (freq = f_start + s*f_step,
// gap cycles, done cycle). The driver pushes one expected output word per cycle
// into exp_q; an independent monitor pops and compares after every clock edge.
module tb_chirp_sequencer;

  localparam int FW = 16;
  localparam int SW = 8;
  localparam int DW = 8;
  localparam int BW = 4;
  localparam int VW = FW + 8;

  // ---------------- clock / reset ----------------
  logic i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  logic          i_rst_n = 1'b0;
  logic          i_ena = 1'b1;
  logic          i_start = 1'b0;
  logic          i_abort = 1'b0;
  logic [FW-1:0] i_f_start = '0;
  logic [FW-1:0] i_f_step = '0;
  logic [SW-1:0] i_n_steps = '0;
  logic [DW-1:0] i_dwell = '0;
  logic [DW-1:0] i_gap = '0;
  logic [BW-1:0] i_n_chirps = '0;
  logic [FW-1:0] o_freq;
  logic          o_nco_en;
  logic          o_chirp_sync;
  logic          o_busy;
  logic          o_done;
  logic [BW-1:0] o_chirp_cnt;

  chirp_sequencer #(.FW(FW), .SW(SW), .DW(DW), .BW(BW)) dut (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .i_ena        (i_ena),
    .i_start      (i_start),
    .i_abort      (i_abort),
    .i_f_start    (i_f_start),
    .i_f_step     (i_f_step),
    .i_n_steps    (i_n_steps),
    .i_dwell      (i_dwell),
    .i_gap        (i_gap),
    .i_n_chirps   (i_n_chirps),
    .o_freq       (o_freq),
    .o_nco_en     (o_nco_en),
    .o_chirp_sync (o_chirp_sync),
    .o_busy       (o_busy),
    .o_done       (o_done),
    .o_chirp_cnt  (o_chirp_cnt)
  );

  // ---------------- scoreboard state ----------------
  logic [VW-1:0] exp_q[$];
  logic [VW-1:0] trace_q[$];
  logic [VW-1:0] cur_exp = '0;
  int            trace_ptr = 0;
  bit            running = 1'b0;
  int            checks = 0;
  int            failures = 0;
  int            cyc_idx = 0;

  // output word: {freq, nco_en, chirp_sync, busy, done, chirp_cnt}
  function automatic logic [VW-1:0] pack(input logic [FW-1:0] f, input logic nco,
                                         input logic sync, input logic busy,
                                         input logic done, input logic [BW-1:0] cnt);
    return {f, nco, sync, busy, done, cnt};
  endfunction

  // ---------------- reference model ----------------
  // Expand a whole burst into its cycle-by-cycle output trace.
  task automatic build_trace(input logic [FW-1:0] f0, input logic [FW-1:0] fs,
                             input int ns, input int dw, input int gp, input int nc);
    logic [31:0] f;
    trace_q.delete();
    for (int c = 0; c <= nc; c++) begin
      for (int s = 0; s <= ns; s++) begin
        f = 32'(f0) + 32'(s) * 32'(fs);
        for (int d = 0; d <= dw; d++)
          trace_q.push_back(pack(f[FW-1:0], 1'b1, (s == 0 && d == 0), 1'b1, 1'b0, BW'(c)));
      end
      if (c < nc)
        for (int g = 0; g < gp; g++)
          trace_q.push_back(pack('0, 1'b0, 1'b0, 1'b1, 1'b0, BW'(c + 1)));
    end
    trace_q.push_back(pack('0, 1'b0, 1'b0, 1'b0, 1'b1, BW'(nc)));
  endtask

  // Configuration changes while a burst runs must have no effect.
  task automatic scramble_cfg();
    i_f_start  = FW'($urandom);
    i_f_step   = FW'($urandom);
    i_n_steps  = SW'($urandom_range(0, 3));
    i_dwell    = DW'($urandom_range(0, 2));
    i_gap      = DW'($urandom_range(0, 3));
    i_n_chirps = BW'($urandom_range(0, 2));
  endtask

  // ---------------- driver ----------------
  // Apply one cycle of inputs at the falling edge and predict the outputs
  // seen after the following rising edge.
  task automatic drive(input logic rs, input logic st, input logic ab, input logic en);
    logic [VW-1:0] e;
    @(negedge i_clk);
    if (running) scramble_cfg();
    i_rst_n = rs;
    i_start = st;
    i_abort = ab;
    i_ena   = en;
    if (!rs) begin
      e = '0;
      running = 1'b0;
    end else if (!en) begin
      e = cur_exp;
      e[6] = 1'b0;
      e[4] = 1'b0;
    end else if (running) begin
      if (ab) begin
        e = '0;
        running = 1'b0;
      end else begin
        e = trace_q[trace_ptr];
        trace_ptr++;
        if (trace_ptr >= trace_q.size()) running = 1'b0;
      end
    end else if (st && !ab) begin
      build_trace(i_f_start, i_f_step, int'(i_n_steps), int'(i_dwell),
                  int'(i_gap), int'(i_n_chirps));
      e = trace_q[0];
      trace_ptr = 1;
      running = 1'b1;
    end else begin
      e = pack('0, 1'b0, 1'b0, 1'b0, 1'b0, cur_exp[BW-1:0]);
    end
    cur_exp = e;
    exp_q.push_back(e);
  endtask

  task automatic set_cfg(input logic [FW-1:0] f0, input logic [FW-1:0] fs, input int ns,
                         input int dw, input int gp, input int nc);
    i_f_start  = f0;
    i_f_step   = fs;
    i_n_steps  = SW'(ns);
    i_dwell    = DW'(dw);
    i_gap      = DW'(gp);
    i_n_chirps = BW'(nc);
  endtask

  // One-cycle start, then run until the model sees the done cycle.
  task automatic run_burst();
    int budget;
    drive(1'b1, 1'b1, 1'b0, 1'b1);
    budget = 0;
    while (running && budget < 2000) begin
      drive(1'b1, 1'b0, 1'b0, 1'b1);
      budget++;
    end
    if (running) begin
      $display("FAIL burst_timeout got=running want=idle");
      failures++;
      running = 1'b0;
    end
    drive(1'b1, 1'b0, 1'b0, 1'b1);
  endtask

  // ---------------- monitor ----------------
  initial begin
    logic [VW-1:0] got;
    logic [VW-1:0] want;
    forever begin
      @(posedge i_clk);
      #1;
      if (exp_q.size() > 0) begin
        want = exp_q.pop_front();
        got = pack(o_freq, o_nco_en, o_chirp_sync, o_busy, o_done, o_chirp_cnt);
        checks++;
        if (got !== want) begin
          failures++;
          $display("FAIL outputs cycle=%0d got freq=%h nco=%b sync=%b busy=%b done=%b cnt=%0d want freq=%h nco=%b sync=%b busy=%b done=%b cnt=%0d",
                   cyc_idx, got[VW-1:8], got[7], got[6], got[5], got[4], got[3:0],
                   want[VW-1:8], want[7], want[6], want[5], want[4], want[3:0]);
        end
        cyc_idx++;
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int budget;
    // reset held with start high, then released idle
    drive(1'b0, 1'b1, 1'b0, 1'b1);
    drive(1'b0, 1'b1, 1'b0, 1'b1);
    repeat (3) drive(1'b1, 1'b0, 1'b0, 1'b1);

    // single up-chirp
    set_cfg(16'h1000, 16'h0100, 3, 1, 0, 0);
    run_burst();
    // down-chirp with wrap
    set_cfg(16'h0080, 16'hFF00, 1, 0, 0, 0);
    run_burst();
    // burst with gap, then back-to-back
    set_cfg(16'h2000, 16'h0010, 1, 0, 3, 2);
    run_burst();
    set_cfg(16'h2000, 16'h0010, 1, 0, 0, 2);
    run_burst();

    // freeze mid-step for 4 cycles
    set_cfg(16'h0400, 16'h0040, 3, 2, 1, 1);
    drive(1'b1, 1'b1, 1'b0, 1'b1);
    repeat (4) drive(1'b1, 1'b0, 1'b0, 1'b1);
    repeat (4) drive(1'b1, 1'b0, 1'b0, 1'b0);
    budget = 0;
    while (running && budget < 200) begin
      drive(1'b1, 1'b0, 1'b0, 1'b1);
      budget++;
    end
    drive(1'b1, 1'b0, 1'b0, 1'b1);

    // abort mid-sweep, then abort held in IDLE blocks start
    set_cfg(16'h0100, 16'h0001, 5, 1, 0, 1);
    drive(1'b1, 1'b1, 1'b0, 1'b1);
    repeat (3) drive(1'b1, 1'b0, 1'b0, 1'b1);
    drive(1'b1, 1'b0, 1'b1, 1'b1);
    repeat (2) drive(1'b1, 1'b1, 1'b1, 1'b1);
    drive(1'b1, 1'b0, 1'b0, 1'b1);

    // start held high through a burst: relaunch right after done
    set_cfg(16'h0300, 16'h0100, 1, 1, 2, 1);
    budget = 0;
    repeat (30) drive(1'b1, 1'b1, 1'b0, 1'b1);
    drive(1'b1, 1'b0, 1'b1, 1'b1);
    drive(1'b1, 1'b0, 1'b0, 1'b1);

    // randomized bursts with freezes, aborts and stray starts
    for (int b = 0; b < 40; b++) begin
      set_cfg(FW'($urandom), FW'($urandom), $urandom_range(0, 5), $urandom_range(0, 3),
              $urandom_range(0, 4), $urandom_range(0, 3));
      drive(1'b1, 1'b1, 1'b0, 1'b1);
      budget = 0;
      while (running && budget < 400) begin
        drive(1'b1, ($urandom_range(0, 3) == 0), ($urandom_range(0, 59) == 0),
              ($urandom_range(0, 9) != 0));
        budget++;
      end
      if (running) begin
        $display("FAIL random_burst_timeout got=running want=idle");
        failures++;
        running = 1'b0;
      end
      repeat ($urandom_range(0, 2)) drive(1'b1, 1'b0, 1'b0, ($urandom_range(0, 1) == 1));
    end
    drive(1'b1, 1'b0, 1'b0, 1'b1);

    // drain scoreboard
    budget = 0;
    while (exp_q.size() > 0 && budget < 20) begin
      @(posedge i_clk);
      budget++;
    end
    #2;
    if (exp_q.size() > 0) begin
      $display("FAIL drain got=%0d want=0", exp_q.size());
      failures++;
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
